// File: rtl/if_fifo.sv
// ---------------------------------------------------------------------------
// if_fifo -- instruction-fetch to decode decoupling buffer
//
// Holds up to DEPTH fetched pc/instruction pairs in an in-order circular
// buffer between the fetch stage and the decode stage. A taken branch or
// jump (flush) throws away everything buffered, including any pair being
// written or read in the same cycle.
//
// Parameters
//   DEPTH     number of buffered entries (power of two, 2..16)
//   CW        width of the occupancy count, log2(DEPTH)+1
//
// Ports
//   clk       single clock, all state changes on its rising edge
//   rst       synchronous, active-high reset (wins over everything)
//   if_valid  fetch stage offers a pc/instruction pair
//   if_pc     address of the offered instruction
//   if_inst   offered instruction word
//   if_ready  buffer has room (count < DEPTH)
//   flush     discard all buffered entries
//   id_ready  decode stage takes the head entry this cycle
//   id_valid  head entry is valid (count > 0)
//   id_pc     pc of the head entry, zero when empty
//   id_inst   instruction of the head entry, zero (NOP) when empty
//   count     number of occupied entries
// ---------------------------------------------------------------------------
module if_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_valid,
  input  logic [31:0]   if_pc,
  input  logic [31:0]   if_inst,
  output logic          if_ready,
  input  logic          flush,
  input  logic          id_ready,
  output logic          id_valid,
  output logic [31:0]   id_pc,
  output logic [31:0]   id_inst,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [AW-1:0] wr_ptr_inc;
  logic [AW-1:0] rd_ptr_inc;
  entry_t        head;

  // -------------------------------------------------------------------------
  // Status. Readiness depends only on the stored occupancy, never on the
  // decode side, so fetch does not see a combinational path from id_ready.
  // -------------------------------------------------------------------------
  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);
  assign if_ready = !full;
  assign id_valid = !empty;
  assign count    = cnt;

  // Flush cancels both the write and the read of the current cycle.
  assign push = if_valid && if_ready && !flush;
  assign pop  = id_valid && id_ready && !flush;

  // Explicit wrap from the last slot back to slot 0.
  assign wr_ptr_inc = (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + AW'(1);
  assign rd_ptr_inc = (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + AW'(1);

  // -------------------------------------------------------------------------
  // Pointers and occupancy. Reset takes precedence over flush, flush over
  // push/pop.
  // -------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr_inc;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Storage. Stale contents are harmless: nothing reaches the outputs unless
  // count says the slot is live.
  // -------------------------------------------------------------------------
  // NOTE: the array is deliberately left out of reset so it can map onto
  // plain register-file or RAM cells without a reset network.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: if_pc, inst: if_inst};
    end
  end

  // -------------------------------------------------------------------------
  // Head presentation. An empty buffer shows pc 0 and a NOP instruction.
  // -------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    head = '0;
    if (!empty) begin
      head = mem[rd_ptr];
    end
  end

  assign id_pc   = head.pc;
  assign id_inst = head.inst;

endmodule

// File: tb/tb_if_fifo.sv
// ---------------------------------------------------------------------------
// tb_if_fifo -- self-checking bench for if_fifo (DEPTH=4, CW=3)
//
// A queue-based reference model follows the buffer's rules at the level of
// "pairs in, pairs out". A compare process checks every DUT output against
// it on each falling edge. Directed sequences add hand-computed literal
// expectations on top of that.
// ---------------------------------------------------------------------------
module tb_if_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk;
  logic          rst;
  logic          if_valid;
  logic [31:0]   if_pc;
  logic [31:0]   if_inst;
  logic          if_ready;
  logic          flush;
  logic          id_ready;
  logic          id_valid;
  logic [31:0]   id_pc;
  logic [31:0]   id_inst;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } pair_t;

  pair_t model_q[$];

  if_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_ready (if_ready),
    .flush    (flush),
    .id_ready (id_ready),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc + 32'h0010_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue. Room is judged on the pre-edge size,
  // so a pop in the same cycle never makes room for a push.
  always @(posedge clk) begin
    if (rst || flush) begin
      model_q.delete();
    end else begin
      bit do_pop;
      bit do_push;
      do_pop  = (model_q.size() > 0) && id_ready;
      do_push = if_valid && (model_q.size() < DEPTH);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back('{pc: if_pc, inst: if_inst});
    end
  end

  // Compare process: every output against the model, every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = model_q.size();
      check("count",    32'(count),    32'(n));
      check("id_valid", 32'(id_valid), 32'(n > 0));
      check("if_ready", 32'(if_ready), 32'(n < DEPTH));
      check("id_pc",    id_pc,   (n > 0) ? model_q[0].pc   : 32'h0);
      check("id_inst",  id_inst, (n > 0) ? model_q[0].inst : 32'h0);
    end
  end

  // Apply one cycle of stimulus, then return #1 after the rising edge.
  task automatic cycle(input logic v, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst_of(pc);
    id_ready = rdy;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset for two cycles with a pair offered: nothing must be stored.
    rst      = 1'b1;
    if_valid = 1'b1;
    if_pc    = 32'hDEAD_BEEF;
    if_inst  = 32'h1234_5678;
    id_ready = 1'b0;
    flush    = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    if_valid = 1'b0;
    check("rst_count",    32'(count),    32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_pc",    id_pc,         32'h0);
    check("rst_id_inst",  id_inst,       32'h0);
    check("rst_if_ready", 32'(if_ready), 32'd1);

    // Fill to full with decode stalled; first push visible one cycle later.
    cycle(1'b1, 32'h0, 1'b0, 1'b0);
    check("latency_valid", 32'(id_valid), 32'd1);
    check("latency_pc",    id_pc,         32'h0);
    cycle(1'b1, 32'h4, 1'b0, 1'b0);
    cycle(1'b1, 32'h8, 1'b0, 1'b0);
    cycle(1'b1, 32'hC, 1'b0, 1'b0);
    check("full_count",    32'(count),    32'd4);
    check("full_if_ready", 32'(if_ready), 32'd0);
    check("full_id_pc",    id_pc,         32'h0);

    // Fifth push while full is dropped.
    cycle(1'b1, 32'h10, 1'b0, 1'b0);
    check("drop_count", 32'(count), 32'd4);
    check("drop_id_pc", id_pc,      32'h0);

    // Drain with fetch still offering: first cycle is pop-only (full), then
    // push+pop. Head must run 0x0,0x4,0x8,0xC,0x10 across the pointer wrap.
    check("drain_head0", id_pc, 32'h0);
    cycle(1'b1, 32'h10, 1'b1, 1'b0);
    check("drain_head1", id_pc, 32'h4);
    check("drain_cnt1",  32'(count), 32'd3);
    cycle(1'b1, 32'h10, 1'b1, 1'b0);
    check("drain_head2", id_pc, 32'h8);
    cycle(1'b1, 32'h14, 1'b1, 1'b0);
    check("drain_head3", id_pc, 32'hC);
    cycle(1'b1, 32'h18, 1'b1, 1'b0);
    check("drain_head4", id_pc,      32'h10);
    check("drain_inst4", id_inst,    inst_of(32'h10));
    check("drain_cnt4",  32'(count), 32'd3);

    // Pop one to reach count=2, then simultaneous push/pop holds count.
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("pp_start_cnt", 32'(count), 32'd2);
    check("pp_start_pc",  id_pc,      32'h14);
    cycle(1'b1, 32'h1C, 1'b1, 1'b0);
    check("pp_cnt_a", 32'(count), 32'd2);
    check("pp_pc_a",  id_pc,      32'h18);
    cycle(1'b1, 32'h20, 1'b1, 1'b0);
    check("pp_cnt_b", 32'(count), 32'd2);
    check("pp_pc_b",  id_pc,      32'h1C);
    cycle(1'b1, 32'h24, 1'b1, 1'b0);
    check("pp_cnt_c", 32'(count), 32'd2);
    check("pp_pc_c",  id_pc,      32'h20);

    // Grow to count=3, then flush with push and pop both requested.
    cycle(1'b1, 32'h28, 1'b0, 1'b0);
    check("pre_flush_cnt", 32'(count), 32'd3);
    cycle(1'b1, 32'h2C, 1'b1, 1'b1);
    check("flush_cnt",   32'(count),    32'd0);
    check("flush_valid", 32'(id_valid), 32'd0);
    check("flush_inst",  id_inst,       32'h0);
    check("flush_pc",    id_pc,         32'h0);
    cycle(1'b1, 32'h30, 1'b0, 1'b0);
    check("post_flush_valid", 32'(id_valid), 32'd1);
    check("post_flush_pc",    id_pc,         32'h30);
    check("post_flush_inst",  id_inst,       inst_of(32'h30));

    // Pop to empty, then pop on empty changes nothing.
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("empty_cnt", 32'(count), 32'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("empty_pop_cnt",   32'(count),    32'd0);
    check("empty_pop_ready", 32'(if_ready), 32'd1);
    cycle(1'b1, 32'h40, 1'b0, 1'b0);
    check("after_empty_pc", id_pc, 32'h40);

    // Mixed traffic, checked entirely by the model.
    for (int i = 0; i < 24; i++) begin
      cycle((i % 3) != 0, 32'h100 + 32'(i * 4), (i % 4) >= 2, i == 15);
    end

    // Reset mid-operation beats flush and push.
    cycle(1'b1, 32'h200, 1'b0, 1'b0);
    cycle(1'b1, 32'h204, 1'b0, 1'b0);
    rst = 1'b1;
    cycle(1'b1, 32'h208, 1'b1, 1'b1);
    rst = 1'b0;
    check("midrst_cnt",   32'(count),    32'd0);
    check("midrst_valid", 32'(id_valid), 32'd0);
    check("midrst_pc",    id_pc,         32'h0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
